// File: rtl/fp_subtractor_seq.sv
// fp_subtractor_seq: iterative IEEE-754 single-precision subtractor, d = a - b.
// Alignment and normalization move one bit per cycle under a small FSM, so
// area stays small and latency depends on the operands.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready only in IDLE)
//   a, b                minuend / subtrahend (latched on accept)
//   out_valid,out_ready result handshake, d held until taken
//   d                   a - b, round-to-nearest-even
//   busy                high whenever the FSM is not IDLE
module fp_subtractor_seq #(
  parameter int unsigned MAX_ALIGN = 27,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADD    = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [9:0] MAX_ALIGN_W = 10'(MAX_ALIGN);

  logic [2:0]         state;
  logic [31:0]        a_r, b_r, d_r;
  logic               sign_l, sign_s;
  logic signed [9:0]  exp_r;
  // Mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S
  logic [27:0]        mant_l, mant_s;
  logic [9:0]         cnt;

  function automatic logic norm_need(input logic [27:0] m, input logic signed [9:0] e);
    return !m[26] && (m != '0) && (e > 10'sd1);
  endfunction

  // Unpack / special-case decode of the latched operands (b_r already negated)
  logic        a_ge;
  logic [31:0] op_l, op_s;
  logic [9:0]  e_l, e_s, diff, align_n;
  logic [27:0] m_l0, m_s0;
  logic        a_nan, b_nan, a_inf, b_inf, special;
  logic [31:0] special_d;

  always_comb begin
    a_ge    = a_r[30:0] >= b_r[30:0];
    op_l    = a_ge ? a_r : b_r;
    op_s    = a_ge ? b_r : a_r;
    e_l     = (op_l[30:23] == 8'd0) ? 10'd1 : {2'b00, op_l[30:23]};
    e_s     = (op_s[30:23] == 8'd0) ? 10'd1 : {2'b00, op_s[30:23]};
    m_l0    = {1'b0, op_l[30:23] != 8'd0, op_l[22:0], 3'b000};
    m_s0    = {1'b0, op_s[30:23] != 8'd0, op_s[22:0], 3'b000};
    diff    = e_l - e_s;
    align_n = (diff > MAX_ALIGN_W) ? MAX_ALIGN_W : diff;
    a_nan   = (&a_r[30:23]) &  (|a_r[22:0]);
    b_nan   = (&b_r[30:23]) &  (|b_r[22:0]);
    a_inf   = (&a_r[30:23]) & ~(|a_r[22:0]);
    b_inf   = (&b_r[30:23]) & ~(|b_r[22:0]);
    special = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (a_r[31] != b_r[31])))
      special_d = CANON_NAN;
    else if (a_inf)
      special_d = a_r;
    else
      special_d = b_r;
  end

  // Magnitude add/subtract with carry folded back into the sticky bit
  logic [27:0]       sum, m_add;
  logic signed [9:0] e_add;

  always_comb begin
    sum = (sign_l == sign_s) ? mant_l + mant_s : mant_l - mant_s;
    if (sum[27]) begin
      m_add = {1'b0, sum[27:2], sum[1] | sum[0]};
      e_add = exp_r + 10'sd1;
    end else begin
      m_add = sum;
      e_add = exp_r;
    end
  end

  logic [27:0]       m_sh;
  logic signed [9:0] e_sh;

  always_comb begin
    m_sh = {mant_l[26:0], 1'b0};
    e_sh = exp_r - 10'sd1;
  end

  // Rounding and packing; a subnormal that rounds into bit 23 picks up exp 1
  logic              rnd_up;
  logic [24:0]       sig;
  logic signed [9:0] e_fin;
  logic [31:0]       pack_d;

  always_comb begin
    rnd_up = mant_l[2] & (mant_l[1] | mant_l[0] | mant_l[3]);
    sig    = {1'b0, mant_l[26:3]} + {24'd0, rnd_up};
    if (sig[24])
      e_fin = exp_r + 10'sd1;
    else if (sig[23])
      e_fin = exp_r;
    else
      e_fin = '0;
    if (sig == '0)
      pack_d = {sign_l & sign_s, 31'd0};
    else if (e_fin >= 10'sd255)
      pack_d = {sign_l, 8'hFF, 23'd0};
    else
      pack_d = {sign_l, e_fin[7:0], sig[24] ? 23'd0 : sig[22:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      d_r    <= '0;
      sign_l <= 1'b0;
      sign_s <= 1'b0;
      exp_r  <= '0;
      mant_l <= '0;
      mant_s <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= {~b[31], b[30:0]};
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (special) begin
            d_r   <= special_d;
            state <= S_DONE;
          end else begin
            sign_l <= op_l[31];
            sign_s <= op_s[31];
            exp_r  <= e_l;
            mant_l <= m_l0;
            mant_s <= m_s0;
            cnt    <= align_n;
            state  <= (align_n == '0) ? S_ADD : S_ALIGN;
          end
        end
        S_ALIGN: begin
          mant_s <= {1'b0, mant_s[27:2], mant_s[1] | mant_s[0]};
          cnt    <= cnt - 10'd1;
          if (cnt == 10'd1) state <= S_ADD;
        end
        S_ADD: begin
          mant_l <= m_add;
          exp_r  <= e_add;
          state  <= norm_need(m_add, e_add) ? S_NORM : S_ROUND;
        end
        S_NORM: begin
          mant_l <= m_sh;
          exp_r  <= e_sh;
          if (!norm_need(m_sh, e_sh)) state <= S_ROUND;
        end
        S_ROUND: begin
          d_r   <= pack_d;
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign d         = d_r;

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Testbench for fp_subtractor_seq: directed vectors with latency, handshake
// stall and mid-operation reset, then randomized operands compared against an
// exact-integer reference model of IEEE-754 subtraction with RNE.
module tb_fp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] d;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  fp_subtractor_seq #(.MAX_ALIGN(27), .CANON_NAN(32'h7FC00000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value of a finite float scaled by 2^149 so every operand is an integer
  function automatic logic [279:0] mag_of(input logic [31:0] x);
    logic [279:0] s;
    int           sh;
    s  = (x[30:23] == 8'd0) ? 280'(x[22:0]) : 280'({1'b1, x[22:0]});
    sh = (x[30:23] == 8'd0) ? 0 : int'(x[30:23]) - 1;
    return s << sh;
  endfunction

  function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic [279:0] mx, my, mag, q, rem, half, one;
    logic         s, up, xn, yn, xi, yi;
    logic [24:0]  sg;
    int           p, sh, e;
    one = 280'd1;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    if (xn || yn) return 32'h7FC00000;
    if (xi && yi) return (x[31] == y[31]) ? 32'h7FC00000 : x;
    if (xi) return x;
    if (yi) return {~y[31], y[30:0]};
    mx = mag_of(x);
    my = mag_of(y);
    if (x[31] != y[31]) begin
      mag = mx + my; s = x[31];
    end else if (mx >= my) begin
      mag = mx - my; s = x[31];
    end else begin
      mag = my - mx; s = ~x[31];
    end
    if (mag == '0) return {x[31] & ~y[31], 31'd0};
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    if (p <= 23) return {s, mag[30:0]};
    sh   = p - 23;
    q    = mag >> sh;
    sg   = q[24:0];
    rem  = mag & ((one << sh) - one);
    half = one << (sh - 1);
    up   = (rem > half) || ((rem == half) && sg[0]);
    sg   = sg + 25'(up);
    if (sg[24]) begin
      sg = sg >> 1;
      sh++;
    end
    e = sh + 1;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), sg[22:0]};
  endfunction

  // One transaction; lat counts cycles from the accept edge to out_valid
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input int unsigned gap,
                        input int unsigned hold, output logic [31:0] res,
                        output int unsigned lat, output logic ok);
    int unsigned w;
    ok  = 1'b0;
    res = '0;
    lat = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    a = xa; b = xb; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      check("result_timeout", 32'(out_valid), 32'd1);
      return;
    end
    res = d;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_d", d, res);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    ok = 1'b1;
  endtask

  function automatic logic [31:0] no_inf(input logic [31:0] x);
    logic [31:0] t;
    t = x;
    if (t[30:23] == 8'hFF) t[30:23] = 8'hFE;
    return t;
  endfunction

  localparam int NDIR = 13;
  logic [31:0]  dir_a   [NDIR] = '{32'h40400000, 32'h3F800000, 32'h3F800001, 32'h4B800000,
                                   32'h00800000, 32'h7F7FFFFF, 32'h7F800000, 32'h80000000,
                                   32'h00000000, 32'h4B800000, 32'hFF800000, 32'h7F800001,
                                   32'h3F800000};
  logic [31:0]  dir_b   [NDIR] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                   32'h00000001, 32'hFF7FFFFF, 32'h7F800000, 32'h00000000,
                                   32'h00000000, 32'h00000001, 32'h7F800000, 32'h3F800000,
                                   32'hFF800000};
  logic [31:0]  dir_d   [NDIR] = '{32'h40000000, 32'h00000000, 32'h34000000, 32'h4B7FFFFF,
                                   32'h007FFFFF, 32'h7F800000, 32'h7FC00000, 32'h80000000,
                                   32'h00000000, 32'h4B800000, 32'hFF800000, 32'h7FC00000,
                                   32'h7F800000};
  int unsigned  dir_lat [NDIR] = '{5, 4, 27, 29, 4, 4, 2, 4, 4, 32, 2, 2, 2};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, ra, rb, t;
    int unsigned lat;
    logic        ok, stale;
    int          e;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_d", d, 32'd0);

    for (int i = 0; i < NDIR; i++) begin
      run_op(dir_a[i], dir_b[i], 0, 0, res, lat, ok);
      if (ok) begin
        check($sformatf("dir%0d_d", i), res, dir_d[i]);
        check($sformatf("dir%0d_lat", i), 32'(lat), 32'(dir_lat[i]));
      end
    end

    // Consumer stall: result must stay put for 5 cycles
    run_op(32'h40400000, 32'h3F800000, 1, 5, res, lat, ok);
    if (ok) begin
      check("stall_d", res, 32'h40000000);
      check("post_hs_out_valid", 32'(out_valid), 32'd0);
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
    end

    // Reset while aligning must drop the operation without a result
    @(negedge clk);
    a = 32'h4B800000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_d", d, 32'd0);
    stale = 1'b0;
    out_ready = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    out_ready = 1'b0;
    check("no_stale", 32'(stale), 32'd0);

    for (int n = 0; n < 1000; n++) begin
      ra = no_inf($urandom);
      if ($urandom_range(0, 7) == 0) ra[30:23] = 8'($urandom_range(0, 2));
      t = $urandom;
      case ($urandom_range(0, 3))
        0: rb = t;
        1: begin
          e = int'(ra[30:23]) + int'($urandom_range(0, 4)) - 2;
          if (e < 0) e = 0;
          if (e > 254) e = 254;
          rb = t;
          rb[30:23] = 8'(e);
        end
        2: begin
          rb = ra ^ 32'($urandom_range(0, 255));
          rb[31] = t[31];
        end
        default: begin
          rb = t;
          rb[30:23] = 8'($urandom_range(0, 2));
        end
      endcase
      rb = no_inf(rb);
      run_op(ra, rb, $urandom_range(0, 2), $urandom_range(0, 2), res, lat, ok);
      if (ok) begin
        if (res !== ref_sub(ra, rb)) $display("  operands a=%h b=%h", ra, rb);
        check("rand_d", res, ref_sub(ra, rb));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
